// File: rtl/fetch_ctrl.sv
// Fetch controller: PC sequencing, jump redirect, halt and
// bubble injection for a small 16-bit instruction pipeline.
module fetch_ctrl #(
    parameter logic [15:0] NOP    = 16'h0000,
    parameter logic [5:0]  OP_HLT = 6'b010001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        stall_pm,
    input  logic [15:0] ins_in,
    output logic [7:0]  pc,
    output logic [15:0] ins_out,
    output logic        bubble,
    output logic        halted,
    output logic [7:0]  stall_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        JUMP = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ins_q, ins_d;
    logic        bub_q, bub_d;
    logic        halt_q, halt_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [5:0]  op;
    logic        is_jmp;
    logic        is_hlt;

    assign op     = ins_q[15:10];
    assign is_jmp = (op[5:2] == 4'b0111);
    assign is_hlt = (op == OP_HLT);

    // Next-state: halt beats jump, jump beats stall; HALT freezes all.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        bub_d   = bub_q;
        halt_d  = halt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN, JUMP: begin
                ins_d = stall_pm ? NOP : ins_in;
                bub_d = stall_pm;
                if (stall && cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (is_hlt) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                    ins_d   = ins_q;
                    bub_d   = bub_q;
                end else if (state_q == RUN) begin
                    if (is_jmp) begin
                        pc_d    = ins_q[7:0];
                        state_d = JUMP;
                    end else if (!stall) begin
                        pc_d = pc_q + 8'd1;
                    end
                end else if (!is_jmp) begin
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= 8'h00;
            ins_q   <= NOP;
            bub_q   <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            bub_q   <= bub_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign ins_out   = ins_q;
    assign bubble    = bub_q;
    assign halted    = halt_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random stimulus
// compared each cycle against a behavioural model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        stall_pm;
    logic [15:0] ins_in;
    logic [7:0]  pc;
    logic [15:0] ins_out;
    logic        bubble;
    logic        halted;
    logic [7:0]  stall_cnt;

    fetch_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .stall_pm  (stall_pm),
        .ins_in    (ins_in),
        .pc        (pc),
        .ins_out   (ins_out),
        .bubble    (bubble),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model
    int          m_pc;
    logic [15:0] m_ins;
    bit          m_bub;
    bit          m_halt;
    int          m_cnt;
    bit          m_redirected;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_ins = 16'h0000;
        m_bub = 0;
        m_halt = 0;
        m_cnt = 0;
        m_redirected = 0;
    endtask

    task automatic model_edge(input bit s, input bit sp,
                              input logic [15:0] d);
        int op;
        bit jmp;
        op = int'(m_ins[15:10]);
        jmp = (op >= 'h1C) && (op <= 'h1F);
        if (m_halt) return;
        if (s) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        if (op == 'h11) begin
            m_halt = 1;
            return;
        end
        if (jmp) begin
            if (!m_redirected) begin
                m_pc = int'(m_ins[7:0]);
                m_redirected = 1;
            end
        end else if (m_redirected) begin
            m_redirected = 0;
        end else if (!s) begin
            m_pc = (m_pc + 1) % 256;
        end
        m_ins = sp ? 16'h0000 : d;
        m_bub = sp;
    endtask

    task automatic check_outs(input string where);
        chk({where, "_pc"}, 32'(pc), 32'(m_pc));
        chk({where, "_ins"}, 32'(ins_out), 32'(m_ins));
        chk({where, "_bubble"}, 32'(bubble), 32'(m_bub));
        chk({where, "_halted"}, 32'(halted), 32'(m_halt));
        chk({where, "_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic cycle(input bit s, input bit sp,
                         input logic [15:0] d);
        stall = s;
        stall_pm = sp;
        ins_in = d;
        @(posedge clk);
        model_edge(s, sp, d);
        #1;
        check_outs("cyc");
    endtask

    // Pulse reset between edges; outputs must clear before next edge.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_pc", 32'(pc), 32'h0);
        chk("arst_ins", 32'(ins_out), 32'h0);
        chk("arst_bubble", 32'(bubble), 32'h0);
        chk("arst_halted", 32'(halted), 32'h0);
        chk("arst_cnt", 32'(stall_cnt), 32'h0);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [15:0] rand_ins();
        int r;
        logic [5:0] op;
        r = $urandom_range(0, 99);
        if (r < 3) return {6'b010001, 10'($urandom)};
        if (r < 15) return {4'b0111, 12'($urandom)};
        do op = 6'($urandom);
        while (op == 6'b010001 || op[5:2] == 4'b0111);
        return {op, 10'($urandom)};
    endfunction

    initial begin
        int halt_run;
        reset = 1'b1;
        stall = 1'b0;
        stall_pm = 1'b0;
        ins_in = 16'h0000;
        model_reset();
        #2;
        check_outs("reset");
        #1;
        reset = 1'b0;

        // Sequential fetch
        repeat (3) cycle(0, 0, 16'h1000);
        chk("seq_pc3", 32'(pc), 32'h3);
        chk("seq_ins", 32'(ins_out), 32'h1000);
        chk("seq_bub", 32'(bubble), 32'h0);
        repeat (2) cycle(0, 0, 16'h1000);
        chk("seq_pc5", 32'(pc), 32'h5);

        // Stall then bubbles
        repeat (2) cycle(1, 0, 16'h1000);
        chk("stall_pc", 32'(pc), 32'h5);
        chk("stall_cnt2", 32'(stall_cnt), 32'h2);
        cycle(0, 1, 16'h1000);
        chk("bub1_ins", 32'(ins_out), 32'h0);
        chk("bub1_flag", 32'(bubble), 32'h1);
        cycle(0, 1, 16'h1000);
        chk("bub2_flag", 32'(bubble), 32'h1);

        // Jump under stall, single redirect
        cycle(0, 0, 16'h7042);
        cycle(1, 0, 16'h7042);
        chk("jmp_pc", 32'(pc), 32'h42);
        repeat (2) cycle(0, 0, 16'h7042);
        chk("jmp_hold", 32'(pc), 32'h42);
        cycle(0, 0, 16'h1000);
        cycle(0, 0, 16'h1000);
        chk("jmp_exit", 32'(pc), 32'h42);
        cycle(0, 0, 16'h1000);
        chk("jmp_run", 32'(pc), 32'h43);

        // Halt freezes everything
        cycle(0, 0, 16'h4400);
        cycle(0, 0, 16'h1000);
        chk("hlt_flag", 32'(halted), 32'h1);
        repeat (10) cycle(1'($urandom), 1'($urandom), rand_ins());
        chk("hlt_pc", 32'(pc), 32'h44);
        chk("hlt_ins", 32'(ins_out), 32'h4400);

        // Asynchronous reset out of HALT
        pulse_reset();
        cycle(0, 0, 16'h1000);
        chk("post_rst_pc", 32'(pc), 32'h1);

        // Wrap
        repeat (254) cycle(0, 0, 16'h1000);
        chk("wrap_ff", 32'(pc), 32'hFF);
        cycle(0, 0, 16'h1000);
        chk("wrap_00", 32'(pc), 32'h0);

        // Saturation
        pulse_reset();
        repeat (300) cycle(1, 0, 16'h1000);
        chk("sat_cnt", 32'(stall_cnt), 32'hFF);
        chk("sat_pc", 32'(pc), 32'h0);

        // Random phase
        halt_run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (halt_run > 8 || $urandom_range(0, 199) == 0) begin
                pulse_reset();
                halt_run = 0;
            end
            cycle($urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0, rand_ins());
            if (m_halt) halt_run++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-high reset, reset.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  stall request from the stall unit; freeze PC.
- stall_pm  input  1  registered stall from the stall unit; inject bubble into the instruction register.
- ins_in  input  16  program-memory read data for the current pc.
- pc  output  8  program-memory address.
- ins_out  output  16  issued instruction; opcode = ins_out[15:10].
- bubble  output  1  high while ins_out holds an injected NOP.
- halted  output  1  sticky halt indication.
- stall_cnt  output  8  saturating count of stalled cycles.
REQ-003 Parameter NOP SHALL default to 16'h0000 and give the bubble instruction value.
REQ-004 Parameter OP_HLT SHALL default to 6'b010001 and give the halt opcode.
REQ-005 Jump opcodes SHALL be exactly those with op[5]=0 and op[4]=op[3]=op[2]=1 (6'b0111xx); jump target = ins_out[7:0].

Function
REQ-006 The block SHALL hold state RUN, JUMP or HALT in a registered encoding; all outputs SHALL be registered.
REQ-007 In RUN, with no jump on ins_out and stall=0, pc SHALL increment by 1 each cycle; 8'hFF SHALL wrap to 8'h00.
REQ-008 In RUN, stall=1 SHALL hold pc unchanged for that cycle.
REQ-009 When ins_out carries a jump opcode in RUN, the block SHALL load pc with ins_out[7:0] on the next edge, regardless of stall, and enter JUMP.
REQ-010 In JUMP, pc SHALL hold; the block SHALL return to RUN on the first cycle ins_out no longer carries a jump opcode, with no second redirect.
REQ-011 The jump redirect SHALL take priority over stall; halt SHALL take priority over both.
REQ-012 When stall_pm=1 and state is not HALT, ins_out SHALL load NOP and bubble SHALL be 1; otherwise ins_out SHALL load ins_in and bubble SHALL be 0.
REQ-013 When ins_out opcode equals OP_HLT, the block SHALL enter HALT on the next edge and set halted=1.
REQ-014 In HALT, pc, ins_out and bubble SHALL freeze; stall, stall_pm and ins_in SHALL be ignored.
REQ-015 HALT SHALL be exited only by reset.
REQ-016 stall_cnt SHALL increment on every edge where stall=1 and state is not HALT.
REQ-017 stall_cnt SHALL saturate at 8'hFF, with no wrap.
REQ-018 If stall and stall_pm are both 1 in the same cycle, pc SHALL hold and ins_out SHALL load NOP together.

Reset
REQ-019 While reset=1 the block SHALL asynchronously force pc=8'h00, ins_out=NOP, bubble=0, halted=0, stall_cnt=8'h00 and state RUN.
REQ-020 Reset asserted mid-jump or in HALT SHALL abandon that state immediately; the first rising edge after deassertion SHALL behave as RUN from pc=0.

Verification
REQ-021 Sequential fetch: reset, then ins_in = 16'h1000 constant with stall=0 for 3 cycles -> pc 0,1,2,3; ins_out=16'h1000; bubble=0.
REQ-022 Stall: pc=5, stall=1 for 2 cycles -> pc stays 5 for 2 cycles; stall_cnt advances by 2; stall_pm=1 the following 2 cycles -> ins_out=16'h0000 and bubble=1 in each of those cycles.
REQ-023 Jump: ins_out=16'h7042 (opcode 6'b011100) with stall=1 -> next pc=8'h42; pc holds while the jump remains on ins_out; exactly one redirect occurs.
REQ-024 Halt: ins_out=16'h4400 (opcode 6'b010001) -> halted=1 next cycle; pc and ins_out frozen for 10 cycles under random stall and ins_in.
REQ-025 Wrap and saturation: pc=8'hFF with stall=0 -> pc=8'h00; 300 consecutive stall cycles -> stall_cnt=8'hFF.
REQ-026 Asynchronous reset: reset pulsed between clock edges while in HALT -> all outputs at reset values before the next edge; pc increments from 0 after deassertion.
